// File: rtl/doodle_pkg.sv
// Shared types and screen/key constants for the doodle motion logic.
package doodle_pkg;

  typedef enum logic [1:0] {StIdle, StRising, StFalling, StDead} state_e;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned DOODLE_W = 8;
  localparam int unsigned DOODLE_H = 16;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_START = 8'h2C;

endpackage

// File: rtl/doodle_motion_platform_hit.sv
// Combinational landing test of the doodle against one platform, using pre-update X/Y.
module platform_hit
  import doodle_pkg::*;
#(
  parameter int PLAT_W = 32
) (
  input  logic        [9:0] x,
  input  logic        [9:0] y,
  input  logic signed [7:0] vy,
  input  logic        [9:0] plat_x,
  input  logic        [9:0] plat_y,
  output logic              hit,
  output logic        [9:0] snap_y
);

  localparam logic signed [10:0] DoodleH = 11'(DOODLE_H);

  logic signed [10:0] y_ext, vy_ext, py_ext, bot_old, bot_new;
  logic        [10:0] x_right, plat_right;

  always_comb begin
    y_ext      = signed'({1'b0, y});
    vy_ext     = signed'({{3{vy[7]}}, vy});
    py_ext     = signed'({1'b0, plat_y});
    bot_old    = y_ext + DoodleH;
    bot_new    = y_ext + vy_ext + DoodleH;
    x_right    = {1'b0, x} + 11'(DOODLE_W);
    plat_right = {1'b0, plat_x} + 11'(PLAT_W);
    hit = (bot_old <= py_ext) && (bot_new >= py_ext) &&
          (x_right > {1'b0, plat_x}) && ({1'b0, x} < plat_right);
    snap_y = plat_y - 10'(DOODLE_H);
  end

endmodule

// File: rtl/doodle_motion.sv
// Doodle position and jump physics, advanced once per rising edge of frame_clk.
module doodle_motion
  import doodle_pkg::*;
#(
  parameter int START_X  = 320,
  parameter int START_Y  = 240,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8,
  parameter int STEP_X   = 2,
  parameter int PLAT_W   = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] PlatX,
  input  logic [9:0] PlatY,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       dead,
  output logic       landed
);

  localparam logic        [10:0] Step     = 11'(STEP_X);
  localparam logic        [10:0] ScrW     = 11'(SCREEN_W);
  localparam logic signed [10:0] DoodleH  = 11'(DOODLE_H);
  localparam logic signed [10:0] ScrH     = 11'(SCREEN_H);
  localparam logic signed [7:0]  VyJump   = 8'(-JUMP_V);
  localparam logic signed [7:0]  Grav     = 8'(GRAVITY);
  localparam logic signed [7:0]  MaxFall  = 8'(MAX_FALL);
  localparam logic signed [7:0]  VyZero   = 8'sd0;

  state_e             state_q, state_d;
  logic        [9:0]  x_q, x_d, y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic               fc_q, landed_q, landed_d, tick;

  logic               hit;
  logic        [9:0]  snap_y;
  logic        [10:0] x_wide, x_move;
  logic signed [10:0] y_sum, y_bot, vy_ext;
  logic signed [7:0]  vy_inc, vy_fall;

  platform_hit #(
    .PLAT_W (PLAT_W)
  ) u_hit (
    .x      (x_q),
    .y      (y_q),
    .vy     (vy_q),
    .plat_x (PlatX),
    .plat_y (PlatY),
    .hit    (hit),
    .snap_y (snap_y)
  );

  assign tick = frame_clk & ~fc_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    landed_d = 1'b0;

    // Horizontal move wraps modulo the screen width.
    x_wide = {1'b0, x_q};
    x_move = x_wide;
    if (keycode == KEY_LEFT) begin
      x_move = (x_wide < Step) ? x_wide + ScrW - Step : x_wide - Step;
    end else if (keycode == KEY_RIGHT) begin
      x_move = (x_wide + Step >= ScrW) ? x_wide + Step - ScrW : x_wide + Step;
    end

    vy_ext  = signed'({{3{vy_q[7]}}, vy_q});
    y_sum   = signed'({1'b0, y_q}) + vy_ext;
    y_bot   = y_sum + DoodleH;
    vy_inc  = vy_q + Grav;
    vy_fall = (vy_inc > MaxFall) ? MaxFall : vy_inc;

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (keycode == KEY_START) begin
            vy_d    = VyJump;
            state_d = StRising;
          end
        end
        StDead: begin
          if (keycode == KEY_START) begin
            x_d     = 10'(START_X);
            y_d     = 10'(START_Y);
            vy_d    = VyJump;
            state_d = StRising;
          end
        end
        StRising, StFalling: begin
          x_d = x_move[9:0];
          if (state_q == StFalling && hit) begin
            y_d      = snap_y;
            vy_d     = VyJump;
            state_d  = StRising;
            landed_d = 1'b1;
          end else if (state_q == StFalling && y_bot >= ScrH) begin
            y_d     = 10'(SCREEN_H - DOODLE_H);
            vy_d    = VyZero;
            state_d = StDead;
          end else begin
            vy_d    = vy_fall;
            y_d     = y_sum[10] ? 10'd0 : y_sum[9:0];
            state_d = (vy_fall <= VyZero) ? StRising : StFalling;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      x_q      <= 10'(START_X);
      y_q      <= 10'(START_Y);
      vy_q     <= VyZero;
      fc_q     <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      fc_q     <= frame_clk;
      landed_q <= landed_d;
    end
  end

  assign BallX     = x_q;
  assign BallY     = y_q;
  assign Ball_size = 10'(DOODLE_W);
  assign dead      = (state_q == StDead);
  assign landed    = landed_q;

endmodule
